arith_req_scheduler: RTL and testbench

// - Shares one ARITHMETIC_UNIT instance between two requesters (port 0, port 1) using round-robin arbitration.
// - Accepts one operation at a time from a valid/ready request channel and drives the unit's operand, function and enable inputs.
// - Captures the unit's registered result and returns it, tagged with the requester id, on a valid/ready response channel.
// - Sits between the control logic and the arithmetic datapath. The unit's reset and clock are shared with this block.

---
 rtl/arith_req_scheduler.sv | 132 +++++++++++++
 tb/tb_arith_req_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_req_scheduler.sv
// Round-robin scheduler sharing one arithmetic unit between two valid/ready requesters.
// Optional macro ARITH_DIV0_CHECK_EN short-circuits divide-by-zero ops with resp_err=1.
module arith_req_scheduler #(
    parameter int WIDTH_IN_DATA  = 16,
    parameter int WIDTH_OUT_DATA = 32
) (
    input  logic                      CLK_arith,
    input  logic                      RST_arith,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [WIDTH_IN_DATA-1:0]  req0_a,
    input  logic [WIDTH_IN_DATA-1:0]  req0_b,
    input  logic [1:0]                req0_fun,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [WIDTH_IN_DATA-1:0]  req1_a,
    input  logic [WIDTH_IN_DATA-1:0]  req1_b,
    input  logic [1:0]                req1_fun,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_id,
    output logic [WIDTH_OUT_DATA:0]   resp_data,
    output logic                      resp_err,
    output logic                      busy,
    output logic [WIDTH_IN_DATA-1:0]  A_arith,
    output logic [WIDTH_IN_DATA-1:0]  B_arith,
    output logic [1:0]                ALU_FUN_arith,
    output logic                      Arith_Enable,
    input  logic [WIDTH_OUT_DATA:0]   Arith_OUT,
    input  logic                      Arith_Flag
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                     state, state_nxt;
    logic                       last_grant;
    logic                       grant_id;
    logic                       accept;
    logic [WIDTH_IN_DATA-1:0]   sel_a, sel_b;
    logic [1:0]                 sel_fun;
    logic                       op_id;
    logic [WIDTH_OUT_DATA:0]    resp_data_q;
`ifdef ARITH_DIV0_CHECK_EN
    logic                       div0;
    logic                       resp_err_q;
`endif

    // Grant the lone requester, or on contention the one that did not win last time.
    always_comb begin
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        accept     = (state == S_IDLE) & (req0_valid | req1_valid);
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
        sel_a      = grant_id ? req1_a   : req0_a;
        sel_b      = grant_id ? req1_b   : req0_b;
        sel_fun    = grant_id ? req1_fun : req0_fun;
`ifdef ARITH_DIV0_CHECK_EN
        div0       = (sel_fun == 2'b11) && (sel_b == '0);
`endif
    end

    always_ff @(posedge CLK_arith or negedge RST_arith) begin
        if (!RST_arith) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef ARITH_DIV0_CHECK_EN
                    state_nxt = div0 ? S_RESP : S_ISSUE;
`else
                    state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (Arith_Flag) state_nxt = S_RESP;
            S_RESP:  if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand registers double as the unit's inputs and hold their value through IDLE.
    always_ff @(posedge CLK_arith or negedge RST_arith) begin
        if (!RST_arith) begin
            last_grant    <= 1'b1;
            A_arith       <= '0;
            B_arith       <= '0;
            ALU_FUN_arith <= '0;
            op_id         <= 1'b0;
            resp_data_q   <= '0;
`ifdef ARITH_DIV0_CHECK_EN
            resp_err_q    <= 1'b0;
`endif
        end else begin
            if (accept) begin
                last_grant    <= grant_id;
                A_arith       <= sel_a;
                B_arith       <= sel_b;
                ALU_FUN_arith <= sel_fun;
                op_id         <= grant_id;
`ifdef ARITH_DIV0_CHECK_EN
                if (div0) begin
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b1;
                end
`endif
            end
            if (state == S_WAIT && Arith_Flag) begin
                resp_data_q <= Arith_OUT;
`ifdef ARITH_DIV0_CHECK_EN
                resp_err_q  <= 1'b0;
`endif
            end
        end
    end

    assign Arith_Enable = (state == S_ISSUE);
    assign resp_valid   = (state == S_RESP);
    assign busy         = (state != S_IDLE);
    assign resp_id      = op_id;
    assign resp_data    = resp_data_q;
`ifdef ARITH_DIV0_CHECK_EN
    assign resp_err     = resp_err_q;
`else
    assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_arith_req_scheduler.sv
// Scoreboard bench for arith_req_scheduler; a behavioural arithmetic unit with
// adjustable latency stands in for the shared datapath.
module tb_arith_req_scheduler;

    logic        CLK_arith, RST_arith;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_fun, req1_fun;
    logic        resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [32:0] resp_data;
    logic [15:0] A_arith, B_arith;
    logic [1:0]  ALU_FUN_arith;
    logic        Arith_Enable, Arith_Flag;
    logic [32:0] Arith_OUT;

    arith_req_scheduler #(.WIDTH_IN_DATA(16), .WIDTH_OUT_DATA(32)) dut (
        .CLK_arith(CLK_arith), .RST_arith(RST_arith),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .A_arith(A_arith), .B_arith(B_arith),
        .ALU_FUN_arith(ALU_FUN_arith), .Arith_Enable(Arith_Enable),
        .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag)
    );

    typedef struct {
        logic        id;
        logic [32:0] data;
        logic        err;
        int          lat;
        int          en;
    } exp_t;

    exp_t exp_q[$];
    int   nvec = 0, nfail = 0;
    int   cyc = 0, acc_cyc = 0, en_cnt = 0, en_base = 0;
    int   unit_lat = 1;

    initial begin
        CLK_arith = 1'b0;
        forever #5 CLK_arith = ~CLK_arith;
    end

    always @(posedge CLK_arith) cyc++;

    // Stand-in arithmetic unit: registered result, Arith_Flag pulses unit_lat edges after enable.
    logic signed [32:0] ua, ub, ures, pend;
    int dly;
    always_comb begin
        ua = {{17{A_arith[15]}}, A_arith};
        ub = {{17{B_arith[15]}}, B_arith};
        case (ALU_FUN_arith)
            2'b00:   ures = ua + ub;
            2'b01:   ures = ua - ub;
            2'b10:   ures = ua * ub;
            default: ures = (ub == 0) ? -33'sd1 : ua / ub;
        endcase
    end

    always @(posedge CLK_arith or negedge RST_arith) begin
        if (!RST_arith) begin
            Arith_Flag <= 1'b0;
            Arith_OUT  <= '0;
            pend       <= '0;
            dly        <= 0;
        end else begin
            Arith_Flag <= 1'b0;
            if (Arith_Enable) begin
                if (unit_lat <= 1) begin
                    Arith_OUT  <= ures;
                    Arith_Flag <= 1'b1;
                end else begin
                    pend <= ures;
                    dly  <= unit_lat - 1;
                end
            end else if (dly != 0) begin
                dly <= dly - 1;
                if (dly == 1) begin
                    Arith_OUT  <= pend;
                    Arith_Flag <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, away from DUT updates.
    logic        prv_rv = 1'b0, prv_hs = 1'b0, prv_id = 1'b0, prv_err = 1'b0;
    logic [32:0] prv_data = '0;
    always @(negedge CLK_arith) begin
        #2;
        if (Arith_Enable) en_cnt++;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_cyc = cyc + 1;
            en_base = en_cnt;
        end
        if (resp_valid) begin
            chk("ready_in_resp", {62'd0, req0_ready, req1_ready}, 64'd0);
            if (!prv_rv) begin
                if (exp_q.size() != 0) begin
                    chk("latency", 64'(cyc - acc_cyc + 1), 64'(exp_q[0].lat));
                    chk("enable_pulses", 64'(en_cnt - en_base), 64'(exp_q[0].en));
                end else chk("resp_expected", 64'(exp_q.size()), 64'd1);
            end else if (!prv_hs) begin
                chk("hold_data", 64'(resp_data), 64'(prv_data));
                chk("hold_id", 64'(resp_id), 64'(prv_id));
                chk("hold_err", 64'(resp_err), 64'(prv_err));
            end
            if (resp_ready) begin
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_id", 64'(resp_id), 64'(e.id));
                    chk("resp_data", 64'(resp_data), 64'(e.data));
                    chk("resp_err", 64'(resp_err), 64'(e.err));
                end else chk("resp_expected", 64'(exp_q.size()), 64'd1);
            end
        end
        prv_rv   = resp_valid;
        prv_hs   = resp_valid && resp_ready;
        prv_data = resp_data;
        prv_id   = resp_id;
        prv_err  = resp_err;
    end

    task automatic drive(input bit port, input bit v, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] fun);
        if (port) begin req1_valid = v; req1_a = a; req1_b = b; req1_fun = fun; end
        else      begin req0_valid = v; req0_a = a; req0_b = b; req0_fun = fun; end
    endtask

    task automatic do_op(input bit port, input logic [15:0] a, input logic [15:0] b, input logic [1:0] fun,
                         input logic [32:0] d, input bit e, input int lat, input int en);
        bit got;
        exp_q.push_back('{id: port, data: d, err: e, lat: lat, en: en});
        @(negedge CLK_arith);
        drive(port, 1'b1, a, b, fun);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (port ? req1_ready : req0_ready) got = 1'b1;
            else @(negedge CLK_arith);
        end
        chk("accept", 64'(got), 64'd1);
        @(posedge CLK_arith);
        @(negedge CLK_arith);
        drive(port, 1'b0, a, b, fun);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge CLK_arith);
        chk("drain", 64'(exp_q.size()), 64'd0);
        @(negedge CLK_arith);
    endtask

    initial begin
        int n;
        RST_arith  = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 2'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 2'd0);
        #2;
        chk("rst_resp", {61'd0, resp_valid, resp_id, resp_err}, 64'd0);
        chk("rst_data", 64'(resp_data), 64'd0);
        chk("rst_unit", {29'd0, A_arith, B_arith, ALU_FUN_arith, Arith_Enable}, 64'd0);
        chk("rst_busy", {62'd0, busy, req0_ready | req1_ready}, 64'd0);
        repeat (2) @(negedge CLK_arith);
        RST_arith = 1'b1;

        // Contention: fresh after reset, requester 0 wins first, then strict alternation.
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{id: 1'b0, data: -33'sd1200, err: 1'b0, lat: 3, en: 1});
            exp_q.push_back('{id: 1'b1, data: 33'sd7,     err: 1'b0, lat: 3, en: 1});
        end
        @(negedge CLK_arith);
        drive(1'b0, 1'b1, 16'sd300, -16'sd4, 2'b10);
        drive(1'b1, 1'b1, 16'sd10, 16'sd3, 2'b01);
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            #1;
            if (req0_ready || req1_ready) n++;
            if (n < 4) @(negedge CLK_arith);
        end
        @(posedge CLK_arith);
        @(negedge CLK_arith);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 2'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 2'd0);
        chk("contend_accepts", 64'(n), 64'd4);
        wait_drain();

        // Single add: 5 + -7 = -2.
        do_op(1'b0, 16'sd5, -16'sd7, 2'b00, -33'sd2, 1'b0, 3, 1);
        wait_drain();
        chk("idle_after_single", 64'(busy), 64'd0);

        // Backpressure: hold off the consumer for 5 cycles; 1000 + -2000 = -1000.
        resp_ready = 1'b0;
        do_op(1'b1, 16'sd1000, -16'sd2000, 2'b00, -33'sd1000, 1'b0, 3, 1);
        for (int i = 0; i < 20 && !resp_valid; i++) begin
            @(negedge CLK_arith);
            #1;
        end
        chk("bp_valid", 64'(resp_valid), 64'd1);
        repeat (5) @(negedge CLK_arith);
        resp_ready = 1'b1;
        wait_drain();
        #1;
        chk("bp_idle", {62'd0, busy, resp_valid}, 64'd0);

        // Divide by zero: 9 / 0.
`ifdef ARITH_DIV0_CHECK_EN
        do_op(1'b0, 16'sd9, 16'sd0, 2'b11, 33'd0, 1'b1, 1, 0);
`else
        do_op(1'b0, 16'sd9, 16'sd0, 2'b11, -33'sd1, 1'b0, 3, 1);
`endif
        wait_drain();

        // Reset while waiting on a slow unit: the op vanishes, nothing is returned.
        unit_lat = 20;
        @(negedge CLK_arith);
        drive(1'b0, 1'b1, 16'sd1, 16'sd2, 2'b00);
        @(posedge CLK_arith);
        @(negedge CLK_arith);
        drive(1'b0, 1'b0, 16'd0, 16'd0, 2'd0);
        @(negedge CLK_arith);
        #1;
        chk("wait_busy", {62'd0, busy, Arith_Enable}, 64'd2);
        RST_arith = 1'b0;
        #1;
        chk("midrst_resp", {61'd0, resp_valid, resp_id, resp_err}, 64'd0);
        chk("midrst_unit", {29'd0, A_arith, B_arith, ALU_FUN_arith, Arith_Enable}, 64'd0);
        chk("midrst_busy", {31'd0, resp_data, busy}, 64'd0);
        @(negedge CLK_arith);
        RST_arith = 1'b1;
        repeat (25) @(negedge CLK_arith);
        #1;
        chk("no_resp_after_rst", 64'(resp_valid), 64'd0);
        unit_lat = 1;

        // 100 / 7 = 14 from requester 1.
        do_op(1'b1, 16'sd100, 16'sd7, 2'b11, 33'sd14, 1'b0, 3, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
